// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the IF/ID register control encoding.
package riscv_pkg;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // What the IF/ID register does on the next edge
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_SQUASH = 2'd2
    } ifid_op_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control from hazard/execute, ROM port, and IF/ID outputs.
interface instruction_fetch_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_instr;
    logic             if_valid;
    logic [WIDTH-1:0] fetch_count;

    // Fetch stage side
    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, if_pc, if_instr, if_valid, fetch_count
    );

    // Surrounding core / ROM side
    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, if_pc, if_instr, if_valid, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, squash to a bubble, or hold.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  ifid_op_e         op,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             if_valid
);

    // Squash keeps the PC of the killed slot so decode still sees a sane if_pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc    <= '0;
            if_instr <= WIDTH'(NOP_INSTR);
            if_valid <= 1'b0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    if_pc    <= pc_in;
                    if_instr <= instr_in;
                    if_valid <= 1'b1;
                end
                IFID_SQUASH: begin
                    if_pc    <= pc_in;
                    if_instr <= WIDTH'(NOP_INSTR);
                    if_valid <= 1'b0;
                end
                default: begin
                    if_pc    <= if_pc;
                    if_instr <= if_instr;
                    if_valid <= if_valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the async instruction ROM, fills IF/ID.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] fetch_count;
    ifid_op_e         op;

    // Low two bits of the target are dropped: no misaligned-fetch trap exists
    assign target = bus.redirect_pc & ~WIDTH'(3);

    // ROM is read combinationally from the live PC
    assign bus.imem_addr   = pc;
    assign bus.fetch_count = fetch_count;

    // Redirect beats stall; stall beats a normal fetch
    always_comb begin
        op = IFID_LOAD;
        if (bus.redirect)   op = IFID_SQUASH;
        else if (bus.stall) op = IFID_HOLD;
    end

    // PC sequencing and count of instructions actually delivered to decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            case (op)
                IFID_SQUASH: pc <= target;
                IFID_LOAD: begin
                    pc          <= pc + WIDTH'(PC_STEP);
                    fetch_count <= fetch_count + 1'b1;
                end
                default: begin
                    pc          <= pc;
                    fetch_count <= fetch_count;
                end
            endcase
        end
    end

    if_id_reg #(.WIDTH(WIDTH)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .pc_in    (pc),
        .instr_in (bus.imem_data),
        .if_pc    (bus.if_pc),
        .if_instr (bus.if_instr),
        .if_valid (bus.if_valid)
    );

endmodule
